// File: rtl/median_filter_ctrl.sv
// rtl/median_filter_ctrl.sv - frame sequencer for the 3x3 median sorter
// Walks the frame in raster order, gathers each neighbourhood and emits the filtered pixel.
module median_filter_ctrl #(
   parameter int IMG_W     = 320,
   parameter int IMG_H     = 240,
   parameter int PIX_W     = 8,
   parameter int ADDR_W    = 17,
   parameter int SORT_WAIT = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 rd_en,
   output logic [ADDR_W-1:0]    rd_addr,
   input  logic [PIX_W-1:0]     rd_data,
   output logic [9*PIX_W-1:0]   win,
   input  logic [PIX_W-1:0]     median_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [PIX_W-1:0]     out_data
);

   localparam int RW    = $clog2(IMG_H);
   localparam int CW    = $clog2(IMG_W);
   localparam int CNT_W = (SORT_WAIT > 9) ? $clog2(SORT_WAIT + 1) : 4;
   localparam logic [ADDR_W-1:0] W_A = ADDR_W'(IMG_W);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SORT, S_WRITE, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [9*PIX_W-1:0]  win_q, win_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [PIX_W-1:0]    out_data_q, out_data_d;

   logic                interior;
   logic [ADDR_W-1:0]   pix_addr;
   logic [ADDR_W-1:0]   nb_off;

   assign pix_addr = ADDR_W'(row_q) * W_A + ADDR_W'(col_q);
   assign interior = (row_q != '0) && (row_q != RW'(IMG_H - 1)) &&
                     (col_q != '0) && (col_q != CW'(IMG_W - 1));

   // Offset of the k-th neighbour from the top-left corner of the window.
   always_comb begin
      nb_off = '0;
      case (cnt_q)
         CNT_W'(1): nb_off = ADDR_W'(1);
         CNT_W'(2): nb_off = ADDR_W'(2);
         CNT_W'(3): nb_off = W_A;
         CNT_W'(4): nb_off = W_A + ADDR_W'(1);
         CNT_W'(5): nb_off = W_A + ADDR_W'(2);
         CNT_W'(6): nb_off = W_A + W_A;
         CNT_W'(7): nb_off = W_A + W_A + ADDR_W'(1);
         CNT_W'(8): nb_off = W_A + W_A + ADDR_W'(2);
         default:   nb_off = '0;
      endcase
   end

   assign rd_en   = (state_q == S_FETCH) &&
                    (interior ? (cnt_q <= CNT_W'(8)) : (cnt_q == '0));
   assign rd_addr = !rd_en   ? '0 :
                    interior ? pix_addr - W_A - ADDR_W'(1) + nb_off : pix_addr;

   assign busy      = (state_q == S_FETCH) || (state_q == S_SORT) || (state_q == S_WRITE);
   assign done      = (state_q == S_DONE);
   assign out_valid = (state_q == S_WRITE);
   assign win       = win_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      cnt_d      = cnt_q;
      win_d      = win_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               row_d   = '0;
               col_d   = '0;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (interior) begin
               // Read data trails its strobe by one cycle, hence slot k fills at count k+1.
               for (int k = 0; k < 9; k++) begin
                  if (cnt_q == CNT_W'(k + 1)) win_d[k*PIX_W +: PIX_W] = rd_data;
               end
               if (cnt_q == CNT_W'(9)) begin
                  cnt_d   = '0;
                  state_d = S_SORT;
               end
            end else if (cnt_q == CNT_W'(1)) begin
               win_d   = {9{rd_data}};
               cnt_d   = '0;
               state_d = S_SORT;
            end
         end
         S_SORT: begin
            if (cnt_q == CNT_W'(SORT_WAIT - 1)) begin
               out_data_d = median_in;
               out_addr_d = pix_addr;
               cnt_d      = '0;
               state_d    = S_WRITE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            if (out_ready) begin
               if (col_q == CW'(IMG_W - 1)) begin
                  col_d = '0;
                  if (row_q == RW'(IMG_H - 1)) begin
                     state_d = S_DONE;
                  end else begin
                     row_d   = row_q + RW'(1);
                     state_d = S_FETCH;
                  end
               end else begin
                  col_d   = col_q + CW'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         cnt_q      <= '0;
         win_q      <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         cnt_q      <= cnt_d;
         win_q      <= win_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// tb/tb_median_filter_ctrl.sv - self-checking bench for median_filter_ctrl
module tb_median_filter_ctrl;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 8;
   localparam int AW = 8;
   localparam int SW = 3;
   localparam int N  = W * H;

   logic            clk = 1'b0;
   logic            reset, start, busy, done, rd_en, out_valid, out_ready;
   logic [AW-1:0]   rd_addr, out_addr;
   logic [PW-1:0]   rd_data = '0;
   logic [PW-1:0]   median_in, out_data;
   logic [9*PW-1:0] win;
   logic [PW-1:0]   mem [N];

   int checks   = 0;
   int failures = 0;
   int rd_log[$];
   int outs_addr[$];
   int outs_data[$];
   int done_cnt = 0;
   int cyc      = 0;
   bit ready_all = 1'b1;

   typedef struct { int test; int addr; int exp; } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   median_filter_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .SORT_WAIT(SW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win(win),
      .median_in(median_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data)
   );

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   function automatic logic [PW-1:0] med9(input logic [9*PW-1:0] w);
      logic [PW-1:0] a [9];
      logic [PW-1:0] t;
      for (int k = 0; k < 9; k++) a[k] = w[k*PW +: PW];
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      return a[4];
   endfunction

   assign median_in = med9(win);

   function automatic bit is_border(input int p);
      return (p / W == 0) || (p / W == H - 1) || (p % W == 0) || (p % W == W - 1);
   endfunction

   function automatic int nb_addr(input int p, input int k);
      return (p / W - 1 + k / 3) * W + (p % W - 1 + k % 3);
   endfunction

   function automatic int ref_pix(input int p);
      logic [9*PW-1:0] w;
      if (is_border(p)) return int'(mem[p]);
      for (int k = 0; k < 9; k++) w[k*PW +: PW] = mem[nb_addr(p, k)];
      return int'(med9(w));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_pixel(input int a);
      int n = is_border(a) ? 1 : 9;
      check("nreads", rd_log.size(), n);
      for (int k = 0; k < n && k < rd_log.size(); k++)
         check("rd_addr", rd_log[k], is_border(a) ? a : nb_addr(a, k));
      for (int k = 0; k < 9; k++)
         check("win_slot", {24'd0, win[k*PW +: PW]},
               is_border(a) ? int'(mem[a]) : int'(mem[nb_addr(a, k)]));
      if (ready_all) check("latency", cyc, is_border(a) ? 2 + SW + 1 : 10 + SW + 1);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         rd_log.delete();
         cyc       = 0;
         ready_all = 1'b1;
      end else begin
         if (busy) cyc++;
         if (out_valid && !out_ready) ready_all = 1'b0;
         if (rd_en) begin
            rd_log.push_back(int'(rd_addr));
            check("rd_excl", {30'd0, out_valid, busy}, 32'd1);
         end
         if (done) done_cnt++;
         if (out_valid && out_ready) begin
            outs_addr.push_back(int'(out_addr));
            outs_data.push_back(int'(out_data));
            check_pixel(int'(out_addr));
            rd_log.delete();
            cyc       = 0;
            ready_all = 1'b1;
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {28'd0, busy, done, rd_en, out_valid}, 32'd0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_out_addr"}, out_addr, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_win"}, (win == '0) ? 1 : 0, 1);
   endtask

   task automatic pulse_start();
      outs_addr.delete();
      outs_data.delete();
      done_cnt = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input bit rnd);
      int t = 0;
      while (done_cnt == 0 && t < 4000) begin
         @(posedge clk); #1;
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         t++;
      end
      out_ready = 1'b1;
      check("done_timeout", (t < 4000) ? 1 : 0, 1);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic wait_outs(input int n);
      int t = 0;
      while (outs_addr.size() < n && t < 2000) begin @(posedge clk); #2; t++; end
      check("outs_timeout", (t < 2000) ? 1 : 0, 1);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_nouts"}, outs_addr.size(), N);
      for (int i = 0; i < N && i < outs_addr.size(); i++) begin
         check({tag, "_out_addr"}, outs_addr[i], i);
         check({tag, "_out_data"}, outs_data[i], ref_pix(i));
      end
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_busy_end"}, {31'd0, busy}, 0);
   endtask

   task automatic check_table(input int test);
      foreach (tbl[i]) begin
         if (tbl[i].test == test && tbl[i].addr < outs_data.size())
            check($sformatf("tbl%0d_pix%0d", test, tbl[i].addr), outs_data[tbl[i].addr], tbl[i].exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) tbl.push_back('{1, i, i});
      for (int i = 0; i < N; i++) tbl.push_back('{2, i, 50});

      reset = 1'b1; start = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < N; i++) mem[i] = PW'(i);
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      reset = 1'b0;

      // index image
      pulse_start();
      wait_done(1'b0);
      check_frame("t1");
      check_table(1);

      // salt noise
      for (int i = 0; i < N; i++) mem[i] = 8'd50;
      mem[5] = 8'd255;
      pulse_start();
      wait_done(1'b0);
      check_frame("t2");
      check_table(2);

      // output back-pressure at pixel 5
      for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 255));
      pulse_start();
      wait_outs(5);
      out_ready = 1'b0;
      begin
         int t = 0;
         while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
         check("stall_wait", (t < 100) ? 1 : 0, 1);
      end
      repeat (7) begin
         @(negedge clk);
         check("stall_valid", {31'd0, out_valid}, 1);
         check("stall_addr", out_addr, 5);
         check("stall_data", out_data, ref_pix(5));
         check("stall_rd_en", {31'd0, rd_en}, 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_done(1'b0);
      check_frame("t3");

      // start while busy is ignored
      for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 255));
      pulse_start();
      wait_outs(3);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(1'b0);
      check_frame("t4");
      repeat (40) @(posedge clk);
      #1;
      check("t4_no_restart", {31'd0, busy}, 0);
      check("t4_single_done", done_cnt, 1);

      // reset while sorting pixel 6
      pulse_start();
      wait_outs(6);
      repeat (10) @(posedge clk);
      #1;
      check("t5_in_sort", {29'd0, busy, rd_en, out_valid}, 32'd4);
      reset = 1'b1;
      @(posedge clk); #1;
      check_zero("t5_reset");
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("t5_no_done", done_cnt, 0);
      check("t5_idle", {31'd0, busy}, 0);
      pulse_start();
      wait_done(1'b0);
      check_frame("t5");

      // random images with random back-pressure
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) mem[i] = PW'($urandom_range(0, 255));
         pulse_start();
         wait_done(1'b1);
         check_frame($sformatf("rnd%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
